seq_divider: RTL and testbench

Multi-cycle 8-bit unsigned divider that complements the single-cycle add/subtract ALU in the datapath. It produces quotient and remainder by restoring division, one quotient bit per clock, using one 9-bit subtract-and-compare per step. The control unit drives it with a start/busy/done handshake and stalls while it is busy.

---
 rtl/div_pkg.sv | 9 +
 rtl/div_step.sv | 24 ++
 rtl/seq_divider.sv | 95 +++++++++
 tb/tb_seq_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_STEPS = DIV_WIDTH;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] t;

  // The stored remainder is always below d, so the difference fits in WIDTH bits.
  always_comb begin
    t      = {r, q_msb};
    q_bit  = (t >= {1'b0, d});
    r_next = q_bit ? (t[WIDTH-1:0] - d) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock, with a
// start/busy/done handshake. A zero divisor short-circuits straight to DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q_msb  (q[WIDTH-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Control FSM, iteration registers and registered results/handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            q   <= dividend;
            d   <= divisor;
            r   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              // Results are defined directly; no iteration needed.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          q   <= {q[WIDTH-2:0], q_bit};
          r   <= r_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            quotient    <= {q[WIDTH-2:0], q_bit};
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain / and %.
module tb_seq_divider;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference: ordinary integer division, with the zero-divisor rule.
  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 8'hFF : 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? a : 8'(int'(a) % int'(b));
  endfunction

  // Wait for done after an accept; returns the cycle at which it arrived and
  // how many of the preceding cycles had busy high. Called just after the accept edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  // Issue one division with a single-cycle start pulse and check everything.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat;
    int bc;
    logic [7:0] eq;
    logic [7:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = $urandom_range(0, 255);
    divisor = $urandom_range(0, 255);
    wait_done(lat, bc);
    chk32({tag, " latency"}, lat, (b == 8'd0) ? 1 : 9);
    chk32({tag, " busy cycles"}, bc, (b == 8'd0) ? 0 : 8);
    chk8({tag, " done"}, 8'(done), 8'd1);
    chk8({tag, " busy at done"}, 8'(busy), 8'd0);
    chk8({tag, " quotient"}, quotient, eq);
    chk8({tag, " remainder"}, remainder, er);
    chk8({tag, " div_by_zero"}, 8'(div_by_zero), (b == 8'd0) ? 8'd1 : 8'd0);
    tick();
    chk8({tag, " done pulse width"}, 8'(done), 8'd0);
    chk8({tag, " quotient hold"}, quotient, eq);
  endtask

  initial begin
    int lat;
    int bc;
    int dones;
    logic [7:0] cap_q;
    logic [7:0] cap_r;
    logic [7:0] ra;
    logic [7:0] rb;

    reset = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    tick();
    tick();
    chk8("reset quotient", quotient, 8'd0);
    chk8("reset remainder", remainder, 8'd0);
    chk8("reset busy", 8'(busy), 8'd0);
    chk8("reset done", 8'(done), 8'd0);
    chk8("reset dbz", 8'(div_by_zero), 8'd0);
    reset = 1'b0;

    run_div("200/7", 8'd200, 8'd7);
    run_div("5/9", 8'd5, 8'd9);
    run_div("255/1", 8'd255, 8'd1);
    run_div("255/255", 8'd255, 8'd255);
    run_div("77/0", 8'd77, 8'd0);
    run_div("200/7 after dbz", 8'd200, 8'd7);

    // Start pulsed during RUN must be ignored.
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    dividend = 8'd9;
    divisor = 8'd2;
    tick();
    start = 1'b0;
    dones = 0;
    cap_q = 8'd0;
    cap_r = 8'd0;
    lat = 0;
    for (int i = 4; i < 20; i++) begin
      if (done) begin
        if (dones == 0) begin
          lat = i;
          cap_q = quotient;
          cap_r = remainder;
        end
        dones++;
      end
      tick();
    end
    chk32("ignored start done count", dones, 1);
    chk32("ignored start latency", lat, 9);
    chk8("100/3 quotient", cap_q, 8'd33);
    chk8("100/3 remainder", cap_r, 8'd1);

    // Reset during RUN step 4 aborts the operation.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk8("pre-abort busy", 8'(busy), 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk8("abort quotient", quotient, 8'd0);
    chk8("abort remainder", remainder, 8'd0);
    chk8("abort busy", 8'(busy), 8'd0);
    chk8("abort done", 8'(done), 8'd0);
    chk8("abort dbz", 8'(div_by_zero), 8'd0);
    chk32("abort state", int'(dut.state), int'(IDLE));
    tick();
    reset = 1'b0;
    run_div("10/3 after abort", 8'd10, 8'd3);

    // Start held high: back-to-back accepts, done 9 cycles apart.
    start = 1'b1;
    dividend = 8'd250;
    divisor = 8'd10;
    tick();
    dividend = 8'd17;
    divisor = 8'd4;
    wait_done(lat, bc);
    chk32("b2b first latency", lat, 9);
    chk8("b2b 250/10 quotient", quotient, 8'd25);
    chk8("b2b 250/10 remainder", remainder, 8'd0);
    tick();
    start = 1'b0;
    chk8("b2b re-accept busy", 8'(busy), 8'd1);
    chk8("b2b done dropped", 8'(done), 8'd0);
    wait_done(lat, bc);
    chk32("b2b second latency", lat, 9);
    chk8("b2b 17/4 quotient", quotient, 8'd4);
    chk8("b2b 17/4 remainder", remainder, 8'd1);
    tick();

    // Randomized operands, zero divisors included now and then.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_div("random", ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
